// File: rtl/instr_fetch.sv
// Instruction fetch stage: IDLE/FETCH/HOLD sequencer with an instruction
// register, field slicing and a supported-opcode check.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_ready,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [6:0]  o_opcode,
  output logic [4:0]  o_rd,
  output logic [2:0]  o_funct3,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [6:0]  o_funct7,
  output logic        o_illegal
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_ir;
  logic [31:0] r_pc;
  logic [31:0] r_fetch_pc;
  logic        w_legal;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_ir       <= 32'h0;
      r_pc       <= 32'h0;
      r_fetch_pc <= RESET_PC;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_enable)
            r_state <= S_FETCH;
        end
        S_FETCH: begin
          // Enable is not consulted here: an issued request always completes.
          if (i_mem_ack) begin
            r_ir       <= i_mem_rdata;
            r_pc       <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + 32'd4;
            r_state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (i_ready)
            r_state <= i_enable ? S_FETCH : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_legal = 1'b0;
    case (r_ir[6:0])
      7'b0110011: w_legal = 1'b1;
      7'b0100011: w_legal = 1'b1;
      7'b0110111: w_legal = 1'b1;
      7'b0010011: w_legal = 1'b1;
      7'b0000011: w_legal = 1'b1;
      default:    w_legal = 1'b0;
    endcase
  end

  assign o_mem_req     = (r_state == S_FETCH);
  assign o_mem_addr    = {r_fetch_pc[31:2], 2'b00};
  assign o_instr_valid = (r_state == S_HOLD);
  assign o_instr       = r_ir;
  assign o_pc          = r_pc;
  assign o_opcode      = r_ir[6:0];
  assign o_rd          = r_ir[11:7];
  assign o_funct3      = r_ir[14:12];
  assign o_rs1         = r_ir[19:15];
  assign o_rs2         = r_ir[24:20];
  assign o_funct7      = r_ir[31:25];
  assign o_illegal     = o_instr_valid & ~w_legal;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0000_0000, the address of the first fetch after reset.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 Reset  in  1  asynchronous, active-high.
REQ-005 Enable  in  1  1 = keep fetching; 0 = stop at the next instruction boundary.
REQ-006 MemReq  out  1  instruction-memory read request.
REQ-007 MemAddr  out  32  read address, word-aligned.
REQ-008 MemAck  in  1  memory returns MemRData in this cycle.
REQ-009 MemRData  in  32  instruction word.
REQ-010 Ready  in  1  decode/Control Unit stage accepts the held instruction.
REQ-011 InstrValid  out  1  Instr and all field outputs hold a valid instruction.
REQ-012 Instr  out  32  held instruction register (IR).
REQ-013 PC  out  32  address of the held instruction.
REQ-014 Opcode  out  7  IR[6:0].
REQ-015 Rd  out  5  IR[11:7].
REQ-016 Funct3  out  3  IR[14:12].
REQ-017 Rs1  out  5  IR[19:15].
REQ-018 Rs2  out  5  IR[24:20].
REQ-019 Funct7  out  7  IR[31:25].
REQ-020 Illegal  out  1  held opcode is not a supported opcode.

Function
REQ-021 The FSM SHALL have three states: IDLE, FETCH and HOLD.
REQ-022 The block SHALL keep an internal fetch pointer FetchPC.
REQ-023 IDLE SHALL drive MemReq=0 and InstrValid=0, and SHALL go to FETCH on the edge where Enable=1.
REQ-024 FETCH SHALL drive MemReq=1 with MemAddr=FetchPC, both held stable until MemAck=1.
REQ-025 On FETCH with MemAck=1, the edge SHALL: capture IR<=MemRData; set PC<=FetchPC; set FetchPC<=FetchPC+4; go to HOLD.
REQ-026 HOLD SHALL drive InstrValid=1 and MemReq=0, and SHALL keep IR and PC unchanged while Ready=0.
REQ-027 On HOLD with Ready=1, the next state SHALL be FETCH if Enable=1, else IDLE.
REQ-028 Latency SHALL be as follows: MemAck in the cycle MemReq first asserts gives InstrValid=1 in the next cycle.
REQ-029 With MemAck and Ready constantly 1, the block SHALL sustain at most one instruction per 2 cycles.
REQ-030 Enable=0 during FETCH SHALL NOT abort the request; the fetch completes, the instruction is delivered in HOLD, then the FSM goes to IDLE.
REQ-031 MemAck SHALL be ignored in IDLE and HOLD.
REQ-032 MemRData SHALL be sampled only on the accepting MemAck edge.
REQ-033 FetchPC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
REQ-034 MemAddr[1:0] SHALL always be 2'b00; MemRData is not checked for alignment.
REQ-035 The supported opcode set SHALL be {0110011, 0100011, 0110111, 0010011, 0000011}.
REQ-036 Illegal SHALL be 1 only when InstrValid=1 and Opcode is outside the supported set; Illegal does not stall the FSM.
REQ-037 The field outputs SHALL be combinational slices of IR, valid only when InstrValid=1.

Reset
REQ-038 Reset=1 SHALL immediately, without waiting for Clk, force: state=IDLE; MemReq=0; InstrValid=0; Illegal=0; IR=0; PC=0; FetchPC=RESET_PC.
REQ-039 Reset asserted mid-FETCH SHALL drop the outstanding request; a MemAck arriving afterwards in IDLE is ignored.
REQ-040 After Reset falls, the first MemAddr SHALL be RESET_PC.

Verification
REQ-041 Reset, Enable=1, MemAck=1 same cycle, MemRData=32'h0000_0033, Ready=1 -> MemAddr 0 then 4 then 8; InstrValid pulses every 2nd cycle; Opcode=0110011; Illegal=0.
REQ-042 Fetch of 32'h4000_0033 with Ready=0 for 5 cycles -> InstrValid=1 held; Funct7=0100000, Funct3=000 and PC stable for all 5 cycles; no MemReq.
REQ-043 MemAck delayed 3 cycles -> MemReq=1 and MemAddr constant for 4 cycles; InstrValid=1 one cycle after MemAck.
REQ-044 RESET_PC=32'hFFFF_FFFC, two fetches -> MemAddr FFFF_FFFC then 0000_0000; PC follows.
REQ-045 MemRData=32'h0000_007F -> Illegal=1 while InstrValid=1; the next fetch proceeds normally.
REQ-046 Reset pulse during FETCH, then MemAck -> MemReq=0 immediately; InstrValid stays 0; the next fetch restarts at RESET_PC.
